// File: rtl/jk_stim_driver_pkg.sv
// Shared definitions for the JK stimulus driver.
//   - Op encodings: each op value is the {j,k} code driven to the downstream stage.
//   - FSM state type and state constants.
//   - Helpers that model the downstream JK stage and pick the state-preserving hold code.
package jk_stim_driver_pkg;

  localparam logic [1:0] OP_CLEAR_BOTH = 2'b00;
  localparam logic [1:0] OP_CLR        = 2'b01;
  localparam logic [1:0] OP_SET        = 2'b10;
  localparam logic [1:0] OP_TOGGLE     = 2'b11;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_DRIVE = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  // Next q of the downstream stage after it clocks {j,k}. Code 00 clears q and qbar.
  function automatic logic jk_next_q(logic [1:0] jk, logic cur_q);
    logic nq;
    nq = 1'b0;
    case (jk)
      OP_SET:    nq = 1'b1;
      OP_CLR:    nq = 1'b0;
      OP_TOGGLE: nq = ~cur_q;
      default:   nq = 1'b0;
    endcase
    return nq;
  endfunction

  // Code that leaves the downstream q unchanged.
  function automatic logic [1:0] hold_code(logic cur_q);
    return cur_q ? OP_SET : OP_CLR;
  endfunction

endpackage

// File: rtl/jk_stim_checker.sv
// Feedback checker for the JK stimulus driver.
// Compares the downstream {q,qbar} against the driver's model every cycle once armed.
// The comparison stays disarmed for the first 2 cycles after reset deassertion, while the
// downstream stage (which has no reset of its own) settles on the reset hold code.
// Ports:
//   clock, reset       - clock and synchronous active-high reset
//   q, qbar            - feedback from the downstream stage
//   exp_q, exp_qbar    - modelled expected values
//   err                - sticky mismatch flag
//   err_cnt            - mismatch count, saturating at all-ones
module jk_stim_checker #(
  parameter int unsigned ERR_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             q,
  input  logic             qbar,
  input  logic             exp_q,
  input  logic             exp_qbar,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  logic [1:0]       arm_q, arm_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] cnt_q, cnt_d;
  logic             armed;
  logic             mismatch;

  assign armed    = (arm_q == 2'd2);
  assign mismatch = ({q, qbar} != {exp_q, exp_qbar});

  always_comb begin
    arm_d = arm_q;
    err_d = err_q;
    cnt_d = cnt_q;
    if (!armed) begin
      arm_d = arm_q + 2'd1;
    end
    if (armed && mismatch) begin
      err_d = 1'b1;
      if (cnt_q != {ERR_W{1'b1}}) begin
        cnt_d = cnt_q + ERR_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      arm_q <= 2'd0;
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      arm_q <= arm_d;
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign err     = err_q;
  assign err_cnt = cnt_q;

endmodule

// File: rtl/jk_stim_driver.sv
// JK stimulus driver: accepts {op,len} commands and drives a registered {j,k} code to a
// downstream JK stage for len cycles, holding the stage's state otherwise.
// Optional feedback checking is enabled by defining JK_STIM_CHECK_EN; without it err and
// err_cnt are tied to 0 and q/qbar are ignored.
// Ports:
//   clock, reset        - clock and synchronous active-high reset
//   cmd_valid/ready     - command handshake (ready only in IDLE)
//   cmd_op, cmd_len     - {j,k} code to drive and number of drive cycles
//   j, k                - registered drive to the downstream stage
//   q, qbar             - feedback from the downstream stage
//   busy, done          - command in progress / one-cycle completion pulse
//   err, err_cnt        - sticky mismatch flag and saturating mismatch count
module jk_stim_driver
  import jk_stim_driver_pkg::*;
#(
  parameter int unsigned CNT_W = 4,
  parameter int unsigned ERR_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_len,
  output logic             j,
  output logic             k,
  input  logic             q,
  input  logic             qbar,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [1:0]       op_q, op_d;
  logic [1:0]       jk_q, jk_d;
  logic             exp_q_q, exp_q_d;
  logic             exp_qbar_q, exp_qbar_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          op_d = cmd_op;
          if (cmd_len == '0) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_DRIVE;
            rem_d   = cmd_len;
          end
        end
      end
      ST_DRIVE: begin
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The model tracks the downstream stage, which clocks the {j,k} currently on the outputs.
  always_comb begin
    exp_q_d    = jk_next_q(jk_q, exp_q_q);
    exp_qbar_d = (jk_q == OP_CLEAR_BOTH) ? 1'b0 : ~exp_q_d;
    // Hold uses the post-edge model value so the code that follows a drive burst keeps
    // whatever the burst's last code produced.
    jk_d       = (state_q == ST_DRIVE) ? op_q : hold_code(exp_q_d);
    // Outputs are registered, so done lands one cycle after the DONE state, in step with j,k.
    done_d     = (state_q == ST_DONE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rem_q      <= '0;
      op_q       <= OP_CLR;
      jk_q       <= OP_CLR;
      exp_q_q    <= 1'b0;
      exp_qbar_q <= 1'b1;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rem_q      <= rem_d;
      op_q       <= op_d;
      jk_q       <= jk_d;
      exp_q_q    <= exp_q_d;
      exp_qbar_q <= exp_qbar_d;
      done_q     <= done_d;
    end
  end

  assign cmd_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign j         = jk_q[1];
  assign k         = jk_q[0];
  assign done      = done_q;

`ifdef JK_STIM_CHECK_EN
  jk_stim_checker #(
    .ERR_W (ERR_W)
  ) u_checker (
    .clock    (clock),
    .reset    (reset),
    .q        (q),
    .qbar     (qbar),
    .exp_q    (exp_q_q),
    .exp_qbar (exp_qbar_q),
    .err      (err),
    .err_cnt  (err_cnt)
  );
`else
  logic unused_fb;
  assign unused_fb = ^{q, qbar, exp_qbar_q};
  assign err       = 1'b0;
  assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_jk_stim_driver.sv
// Directed bench for jk_stim_driver with a behavioural JK stage on the feedback path.
module tb_jk_stim_driver;

  localparam logic [1:0] OP_CLEAR_BOTH = 2'b00;
  localparam logic [1:0] OP_CLR        = 2'b01;
  localparam logic [1:0] OP_SET        = 2'b10;
  localparam logic [1:0] OP_TOGGLE     = 2'b11;

`ifdef JK_STIM_CHECK_EN
  localparam int CHK = 1;
`else
  localparam int CHK = 0;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [3:0] cmd_len;
  logic       j, k;
  logic       q, qbar;
  logic       busy, done, err;
  logic [7:0] err_cnt;

  logic sq, sqb;
  logic force_q1;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  // Downstream JK stage; 00 loads q=0, qbar=0.
  always @(posedge clock) begin
    case ({j, k})
      2'b00:   begin sq <= 1'b0; sqb <= 1'b0; end
      2'b01:   begin sq <= 1'b0; sqb <= 1'b1; end
      2'b10:   begin sq <= 1'b1; sqb <= 1'b0; end
      default: begin sq <= ~sq;  sqb <= sq;   end
    endcase
  end

  assign q    = force_q1 ? 1'b1 : sq;
  assign qbar = sqb;

  jk_stim_driver #(
    .CNT_W (4),
    .ERR_W (8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_len   (cmd_len),
    .j         (j),
    .k         (k),
    .q         (q),
    .qbar      (qbar),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Offer a command and let it be accepted at the next edge (edge N).
  task automatic issue(input logic [1:0] op, input logic [3:0] len);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_len   = len;
    chk("ready_at_offer", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  logic saw_done;

  initial begin
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_len   = 4'd0;
    force_q1  = 1'b0;
    repeat (3) tick();
    chk("rst_jk",    {30'd0, j, k}, 32'h1);
    chk("rst_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_done",  {31'd0, done}, 32'd0);
    chk("rst_err",   {31'd0, err}, 32'd0);
    chk("rst_cnt",   {24'd0, err_cnt}, 32'd0);
    reset = 1'b0;
    tick();
    tick();

    // SET len=1
    issue(OP_SET, 4'd1);
    chk("set_n_jk",    {30'd0, j, k}, 32'h1);
    chk("set_n_busy",  {31'd0, busy}, 32'd1);
    chk("set_n_ready", {31'd0, cmd_ready}, 32'd0);
    tick();
    chk("set_drive_jk", {30'd0, j, k}, 32'h2);
    chk("set_drive_done", {31'd0, done}, 32'd0);
    tick();
    chk("set_hold_jk", {30'd0, j, k}, 32'h2);
    chk("set_done",    {31'd0, done}, 32'd1);
    chk("set_q",       {31'd0, q}, 32'd1);
    chk("set_ready",   {31'd0, cmd_ready}, 32'd1);
    tick();
    chk("set_done_off", {31'd0, done}, 32'd0);
    chk("set_err",      {31'd0, err}, 32'd0);

    // CLR len=1 to bring q back to 0
    issue(OP_CLR, 4'd1);
    tick();
    tick();
    chk("clr_q",    {31'd0, q}, 32'd0);
    chk("clr_done", {31'd0, done}, 32'd1);
    tick();

    // TOGGLE len=3 from q=0
    issue(OP_TOGGLE, 4'd3);
    chk("tog_n_jk", {30'd0, j, k}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("tog_drive_jk", {30'd0, j, k}, 32'h3);
    end
    tick();
    chk("tog_hold_jk", {30'd0, j, k}, 32'h2);
    chk("tog_done",    {31'd0, done}, 32'd1);
    chk("tog_q",       {31'd0, q}, 32'd1);
    tick();
    chk("tog_hold2_jk", {30'd0, j, k}, 32'h2);
    chk("tog_cnt",      {24'd0, err_cnt}, 32'd0);

    // CLR len=0: straight to DONE, no 01 drive
    issue(OP_CLR, 4'd0);
    chk("len0_jk",    {30'd0, j, k}, 32'h2);
    chk("len0_ready", {31'd0, cmd_ready}, 32'd0);
    chk("len0_busy",  {31'd0, busy}, 32'd1);
    chk("len0_done0", {31'd0, done}, 32'd0);
    tick();
    chk("len0_done",   {31'd0, done}, 32'd1);
    chk("len0_ready1", {31'd0, cmd_ready}, 32'd1);
    chk("len0_jk2",    {30'd0, j, k}, 32'h2);
    chk("len0_q",      {31'd0, q}, 32'd1);

    // CLEAR_BOTH len=1
    issue(OP_CLEAR_BOTH, 4'd1);
    chk("cb_n_jk", {30'd0, j, k}, 32'h2);
    tick();
    chk("cb_drive_jk", {30'd0, j, k}, 32'h0);
    tick();
    chk("cb_q",    {31'd0, q}, 32'd0);
    chk("cb_qbar", {31'd0, qbar}, 32'd0);
    chk("cb_done", {31'd0, done}, 32'd1);
    chk("cb_jk",   {30'd0, j, k}, 32'h1);
    chk("cb_err",  {31'd0, err}, 32'd0);
    tick();
    chk("cb_jk2",   {30'd0, j, k}, 32'h1);
    chk("cb_qbar2", {31'd0, qbar}, 32'd1);
    chk("cb_err2",  {31'd0, err}, 32'd0);

    // q stuck-at-1 during CLR len=5; model expects q=0 so every armed cycle mismatches
    force_q1 = 1'b1;
    issue(OP_CLR, 4'd5);
    chk("stuck_err",  {31'd0, err}, CHK);
    chk("stuck_cnt1", {24'd0, err_cnt}, CHK * 1);
    tick();
    chk("stuck_cnt2", {24'd0, err_cnt}, CHK * 2);
    tick();
    chk("stuck_cnt3", {24'd0, err_cnt}, CHK * 3);
    repeat (300) tick();
    chk("stuck_sat",  {24'd0, err_cnt}, CHK * 255);
    chk("stuck_err2", {31'd0, err}, CHK);
    force_q1 = 1'b0;

    // Reset in the middle of TOGGLE len=8
    issue(OP_TOGGLE, 4'd8);
    tick();
    tick();
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    tick();
    chk("abort_ready", {31'd0, cmd_ready}, 32'd1);
    chk("abort_busy",  {31'd0, busy}, 32'd0);
    chk("abort_jk",    {30'd0, j, k}, 32'h1);
    chk("abort_done",  {31'd0, done}, 32'd0);
    chk("abort_cnt",   {24'd0, err_cnt}, 32'd0);
    chk("abort_err",   {31'd0, err}, 32'd0);
    reset    = 1'b0;
    saw_done = 1'b0;
    repeat (12) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", {31'd0, saw_done}, 32'd0);
    chk("abort_cnt2",    {24'd0, err_cnt}, 32'd0);
    chk("abort_jk2",     {30'd0, j, k}, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
